// File: rtl/frame_ecc_pkg.sv
// rtl/frame_ecc_pkg.sv - shared types, field layout and helpers for the frame ECC monitor
package frame_ecc_pkg;

  // Frame geometry of the configuration memory readback
  localparam int FRAME_WORDS = 41;

  // Syndrome and log entry field layout
  localparam int SYN_W     = 12;
  localparam int TYPE_W    = 2;
  localparam int WORD_W    = 6;
  localparam int BIT_W     = 5;
  localparam int BIT_LSB   = 0;
  localparam int WORD_LSB  = BIT_LSB + BIT_W;
  localparam int PARITY_IX = WORD_LSB + WORD_W;

  typedef enum logic [1:0] {
    ECC_CLEAN = 2'b00,
    ECC_SBE   = 2'b01,
    ECC_MBE   = 2'b10
  } ecc_type_e;

  // Increment that sticks at max_value instead of wrapping
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] max_value);
    return (value >= max_value) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/frame_ecc_log_fifo.sv
// rtl/frame_ecc_log_fifo.sv - first-word-fall-through error log FIFO
module frame_ecc_log_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A full FIFO still takes a push when the head leaves in the same cycle
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

  // Pointer update; the extra MSB separates full from empty
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Entry storage, written at the tail
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/frame_ecc_monitor.sv
// rtl/frame_ecc_monitor.sv - classifies frame ECC syndromes, counts and logs errors, raises IRQ
module frame_ecc_monitor
  import frame_ecc_pkg::*;
#(
  parameter int NUM_FRAMES = 1024,
  parameter int LOG_DEPTH  = 8,
  parameter int CNT_W      = 16,
  localparam int FW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1,
  localparam int LW = TYPE_W + FW + WORD_W + BIT_W
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             ERROR,
  input  logic [SYN_W-1:0] SYNDROME,
  input  logic             SYNDROMEVALID,
  input  logic             SCAN_START,
  input  logic             CNT_CLR,
  input  logic             IRQ_CLR,
  output logic             LOG_VALID,
  input  logic             LOG_READY,
  output logic [LW-1:0]    LOG_DATA,
  output logic [CNT_W-1:0] SBE_COUNT,
  output logic [CNT_W-1:0] MBE_COUNT,
  output logic             LOG_OVF,
  output logic             SCAN_DONE,
  output logic             IRQ
);

  localparam logic [FW-1:0]    LAST_FRAME = FW'(NUM_FRAMES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  logic             s1_err;
  logic             s1_valid;
  logic [SYN_W-1:0] s1_syn;
  ecc_type_e        cls;
  logic             is_sbe;
  logic             is_mbe;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [FW-1:0]    frame_idx;
  logic [LW-1:0]    entry;

  // Stage 1: capture the primitive outputs unconditionally
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      s1_err   <= 1'b0;
      s1_valid <= 1'b0;
      s1_syn   <= '0;
    end else begin
      s1_err   <= ERROR;
      s1_valid <= SYNDROMEVALID;
      s1_syn   <= SYNDROME;
    end
  end

  // Stage 2 classification: only an in-frame location with odd overall parity is correctable
  always_comb begin
    cls = ECC_CLEAN;
    if (s1_valid && s1_err) begin
      if (s1_syn == '0) begin
        cls = ECC_MBE;
      end else if (s1_syn[PARITY_IX] && (s1_syn[WORD_LSB +: WORD_W] < WORD_W'(FRAME_WORDS))) begin
        cls = ECC_SBE;
      end else begin
        cls = ECC_MBE;
      end
    end
  end

  assign is_sbe = (cls == ECC_SBE);
  assign is_mbe = (cls == ECC_MBE);
  assign push   = is_sbe || is_mbe;
  assign pop    = LOG_VALID && LOG_READY;
  assign entry  = {cls, frame_idx, s1_syn[WORD_LSB +: WORD_W], s1_syn[BIT_LSB +: BIT_W]};

  assign LOG_VALID = !fifo_empty;

  frame_ecc_log_fifo #(
    .DEPTH (LOG_DEPTH),
    .WIDTH (LW)
  ) u_log_fifo (
    .clk    (CLK),
    .resetn (RST_N),
    .push   (push),
    .wdata  (entry),
    .pop    (pop),
    .rdata  (LOG_DATA),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // Frame index tracking; a scan restart overrides the per-frame advance
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      frame_idx <= '0;
      SCAN_DONE <= 1'b0;
    end else begin
      SCAN_DONE <= s1_valid && (frame_idx == LAST_FRAME);
      if (SCAN_START) begin
        frame_idx <= '0;
      end else if (s1_valid) begin
        frame_idx <= (frame_idx == LAST_FRAME) ? '0 : frame_idx + 1'b1;
      end
    end
  end

  // Saturating error counters; a clear wins over a coincident increment
  always_ff @(posedge CLK) begin
    if (!RST_N || CNT_CLR) begin
      SBE_COUNT <= '0;
      MBE_COUNT <= '0;
    end else begin
      if (is_sbe) SBE_COUNT <= CNT_W'(sat_inc(32'(SBE_COUNT), 32'(CNT_MAX)));
      if (is_mbe) MBE_COUNT <= CNT_W'(sat_inc(32'(MBE_COUNT), 32'(CNT_MAX)));
    end
  end

  // Sticky flags: IRQ on uncorrectable results, overflow when an entry is dropped
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      IRQ     <= 1'b0;
      LOG_OVF <= 1'b0;
    end else begin
      if (is_mbe) begin
        IRQ <= 1'b1;
      end else if (IRQ_CLR) begin
        IRQ <= 1'b0;
      end
      if (CNT_CLR) begin
        LOG_OVF <= 1'b0;
      end else if (push && fifo_full && !pop) begin
        LOG_OVF <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_frame_ecc_monitor.sv
// tb/tb_frame_ecc_monitor.sv - directed self-checking bench for frame_ecc_monitor
module tb_frame_ecc_monitor;

  logic        CLK;
  logic        RST_N;
  logic        ERROR;
  logic [11:0] SYNDROME;
  logic        SYNDROMEVALID;
  logic        SCAN_START;
  logic        CNT_CLR;
  logic        IRQ_CLR;
  logic        LOG_READY;

  logic        a_log_valid, a_ovf, a_done, a_irq;
  logic [22:0] a_log_data;
  logic [15:0] a_sbe, a_mbe;
  logic        b_log_valid, b_ovf, b_done, b_irq;
  logic [14:0] b_log_data;
  logic [1:0]  b_sbe, b_mbe;

  int checks;
  int errors;

  frame_ecc_monitor #(.NUM_FRAMES(1024), .LOG_DEPTH(8), .CNT_W(16)) dut_a (
    .CLK(CLK), .RST_N(RST_N), .ERROR(ERROR), .SYNDROME(SYNDROME), .SYNDROMEVALID(SYNDROMEVALID),
    .SCAN_START(SCAN_START), .CNT_CLR(CNT_CLR), .IRQ_CLR(IRQ_CLR), .LOG_VALID(a_log_valid),
    .LOG_READY(LOG_READY), .LOG_DATA(a_log_data), .SBE_COUNT(a_sbe), .MBE_COUNT(a_mbe),
    .LOG_OVF(a_ovf), .SCAN_DONE(a_done), .IRQ(a_irq)
  );

  frame_ecc_monitor #(.NUM_FRAMES(4), .LOG_DEPTH(8), .CNT_W(2)) dut_b (
    .CLK(CLK), .RST_N(RST_N), .ERROR(ERROR), .SYNDROME(SYNDROME), .SYNDROMEVALID(SYNDROMEVALID),
    .SCAN_START(SCAN_START), .CNT_CLR(CNT_CLR), .IRQ_CLR(IRQ_CLR), .LOG_VALID(b_log_valid),
    .LOG_READY(LOG_READY), .LOG_DATA(b_log_data), .SBE_COUNT(b_sbe), .MBE_COUNT(b_mbe),
    .LOG_OVF(b_ovf), .SCAN_DONE(b_done), .IRQ(b_irq)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic e, input logic [11:0] s);
    ERROR = e;
    SYNDROME = s;
    SYNDROMEVALID = 1'b1;
    step();
    SYNDROMEVALID = 1'b0;
    ERROR = 1'b0;
    SYNDROME = 12'h000;
  endtask

  task automatic apply_reset();
    ERROR = 1'b0; SYNDROME = 12'h000; SYNDROMEVALID = 1'b0;
    SCAN_START = 1'b0; CNT_CLR = 1'b0; IRQ_CLR = 1'b0; LOG_READY = 1'b0;
    RST_N = 1'b0;
    step();
    step();
    RST_N = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (a_log_valid !== 1'b0) begin errors++; $display("FAIL reset_log_valid got %b exp 0", a_log_valid); end
    checks++; if (a_sbe !== 16'd0 || a_mbe !== 16'd0) begin errors++; $display("FAIL reset_counts got %0d/%0d exp 0/0", a_sbe, a_mbe); end
    checks++; if ({a_ovf, a_done, a_irq} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {a_ovf, a_done, a_irq}); end
    checks++; if ({b_log_valid, b_ovf, b_done, b_irq, b_sbe, b_mbe} !== 8'h00) begin errors++; $display("FAIL reset_b got %h exp 00", {b_log_valid, b_ovf, b_done, b_irq, b_sbe, b_mbe}); end
  endtask

  task automatic test_clean();
    apply_reset();
    for (int i = 0; i < 4; i++) drive(1'b0, 12'hC25);
    step();
    step();
    checks++; if (a_log_valid !== 1'b0) begin errors++; $display("FAIL clean_log_valid got %b exp 0", a_log_valid); end
    checks++; if (a_sbe !== 16'd0 || a_mbe !== 16'd0) begin errors++; $display("FAIL clean_counts got %0d/%0d exp 0/0", a_sbe, a_mbe); end
    drive(1'b1, 12'hC25);
    step();
    checks++; if (a_log_data !== {2'b01, 10'd4, 6'd33, 5'd5}) begin errors++; $display("FAIL clean_frame_idx got %h exp %h", a_log_data, {2'b01, 10'd4, 6'd33, 5'd5}); end
  endtask

  task automatic test_sbe();
    apply_reset();
    for (int i = 0; i < 3; i++) drive(1'b0, 12'h000);
    drive(1'b1, 12'hC25);
    checks++; if (a_log_valid !== 1'b0) begin errors++; $display("FAIL sbe_latency_early got %b exp 0", a_log_valid); end
    step();
    checks++; if (a_log_valid !== 1'b1) begin errors++; $display("FAIL sbe_log_valid got %b exp 1", a_log_valid); end
    checks++; if (a_log_data !== {2'b01, 10'd3, 6'd33, 5'd5}) begin errors++; $display("FAIL sbe_entry got %h exp %h", a_log_data, {2'b01, 10'd3, 6'd33, 5'd5}); end
    checks++; if (a_sbe !== 16'd1 || a_mbe !== 16'd0) begin errors++; $display("FAIL sbe_counts got %0d/%0d exp 1/0", a_sbe, a_mbe); end
    checks++; if (a_irq !== 1'b0) begin errors++; $display("FAIL sbe_irq got %b exp 0", a_irq); end
    LOG_READY = 1'b1;
    step();
    LOG_READY = 1'b0;
    checks++; if (a_log_valid !== 1'b0) begin errors++; $display("FAIL sbe_pop got %b exp 0", a_log_valid); end
  endtask

  task automatic test_mbe();
    apply_reset();
    LOG_READY = 1'b1;
    drive(1'b1, 12'h042);
    step();
    checks++; if (a_mbe !== 16'd1 || a_irq !== 1'b1) begin errors++; $display("FAIL mbe_first got mbe=%0d irq=%b exp 1/1", a_mbe, a_irq); end
    checks++; if (a_log_data !== {2'b10, 10'd0, 6'd2, 5'd2}) begin errors++; $display("FAIL mbe_entry got %h exp %h", a_log_data, {2'b10, 10'd0, 6'd2, 5'd2}); end
    IRQ_CLR = 1'b1;
    step();
    IRQ_CLR = 1'b0;
    checks++; if (a_irq !== 1'b0) begin errors++; $display("FAIL irq_clr got %b exp 0", a_irq); end
    drive(1'b1, 12'h000);
    IRQ_CLR = 1'b1;
    step();
    IRQ_CLR = 1'b0;
    checks++; if (a_irq !== 1'b1) begin errors++; $display("FAIL irq_set_wins got %b exp 1", a_irq); end
    checks++; if (a_log_data !== {2'b10, 10'd1, 6'd0, 5'd0} || a_mbe !== 16'd2) begin errors++; $display("FAIL mbe_zero_syn got %h/%0d exp %h/2", a_log_data, a_mbe, {2'b10, 10'd1, 6'd0, 5'd0}); end
    drive(1'b1, 12'hFE0);
    step();
    checks++; if (a_log_data !== {2'b10, 10'd2, 6'd63, 5'd0} || a_mbe !== 16'd3) begin errors++; $display("FAIL mbe_out_of_frame got %h/%0d exp %h/3", a_log_data, a_mbe, {2'b10, 10'd2, 6'd63, 5'd0}); end
    drive(1'b1, 12'hD07);
    step();
    checks++; if (a_log_data !== {2'b01, 10'd3, 6'd40, 5'd7} || a_sbe !== 16'd1) begin errors++; $display("FAIL sbe_word40 got %h/%0d exp %h/1", a_log_data, a_sbe, {2'b01, 10'd3, 6'd40, 5'd7}); end
    drive(1'b1, 12'hD20);
    step();
    checks++; if (a_log_data !== {2'b10, 10'd4, 6'd41, 5'd0} || a_mbe !== 16'd4) begin errors++; $display("FAIL mbe_word41 got %h/%0d exp %h/4", a_log_data, a_mbe, {2'b10, 10'd4, 6'd41, 5'd0}); end
    LOG_READY = 1'b0;
  endtask

  task automatic test_overflow();
    int n;
    apply_reset();
    for (int i = 0; i < 9; i++) drive(1'b1, 12'hC25);
    step();
    checks++; if (a_sbe !== 16'd9 || a_ovf !== 1'b1) begin errors++; $display("FAIL ovf_state got sbe=%0d ovf=%b exp 9/1", a_sbe, a_ovf); end
    checks++; if (a_log_valid !== 1'b1 || a_log_data !== {2'b01, 10'd0, 6'd33, 5'd5}) begin errors++; $display("FAIL ovf_head got %b/%h exp 1/%h", a_log_valid, a_log_data, {2'b01, 10'd0, 6'd33, 5'd5}); end
    step();
    checks++; if (a_log_data !== {2'b01, 10'd0, 6'd33, 5'd5}) begin errors++; $display("FAIL ovf_head_stable got %h exp %h", a_log_data, {2'b01, 10'd0, 6'd33, 5'd5}); end
    n = 0;
    LOG_READY = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (!a_log_valid) break;
      checks++; if (a_log_data[20:11] !== 10'(n)) begin errors++; $display("FAIL ovf_drain_frame got %0d exp %0d", a_log_data[20:11], n); end
      n++;
      step();
    end
    LOG_READY = 1'b0;
    checks++; if (n !== 8) begin errors++; $display("FAIL ovf_drain_count got %0d exp 8", n); end
    CNT_CLR = 1'b1;
    step();
    CNT_CLR = 1'b0;
    checks++; if (a_sbe !== 16'd0 || a_ovf !== 1'b0) begin errors++; $display("FAIL cnt_clr got sbe=%0d ovf=%b exp 0/0", a_sbe, a_ovf); end
  endtask

  task automatic test_full_pop();
    int n;
    apply_reset();
    for (int i = 0; i < 9; i++) drive(1'b1, 12'hC25);
    LOG_READY = 1'b1;
    step();
    LOG_READY = 1'b0;
    checks++; if (a_ovf !== 1'b0 || a_sbe !== 16'd9) begin errors++; $display("FAIL full_pop_state got ovf=%b sbe=%0d exp 0/9", a_ovf, a_sbe); end
    n = 0;
    LOG_READY = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (!a_log_valid) break;
      checks++; if (a_log_data[20:11] !== 10'(n + 1)) begin errors++; $display("FAIL full_pop_frame got %0d exp %0d", a_log_data[20:11], n + 1); end
      n++;
      step();
    end
    LOG_READY = 1'b0;
    checks++; if (n !== 8) begin errors++; $display("FAIL full_pop_count got %0d exp 8", n); end
  endtask

  task automatic test_scan();
    apply_reset();
    for (int i = 0; i < 4; i++) drive(1'b0, 12'h000);
    checks++; if (b_done !== 1'b0) begin errors++; $display("FAIL scan_done_early got %b exp 0", b_done); end
    step();
    checks++; if (b_done !== 1'b1 || a_done !== 1'b0) begin errors++; $display("FAIL scan_done got b=%b a=%b exp 1/0", b_done, a_done); end
    step();
    checks++; if (b_done !== 1'b0) begin errors++; $display("FAIL scan_done_pulse got %b exp 0", b_done); end
    drive(1'b1, 12'hC25);
    step();
    checks++; if (b_log_data !== {2'b01, 2'd0, 6'd33, 5'd5}) begin errors++; $display("FAIL scan_wrap got %h exp %h", b_log_data, {2'b01, 2'd0, 6'd33, 5'd5}); end
    apply_reset();
    drive(1'b0, 12'h000);
    drive(1'b0, 12'h000);
    step();
    SCAN_START = 1'b1;
    step();
    SCAN_START = 1'b0;
    drive(1'b1, 12'hC25);
    step();
    checks++; if (b_log_data !== {2'b01, 2'd0, 6'd33, 5'd5} || a_log_data[20:11] !== 10'd0) begin errors++; $display("FAIL scan_start got b=%h a_frame=%0d exp %h/0", b_log_data, a_log_data[20:11], {2'b01, 2'd0, 6'd33, 5'd5}); end
  endtask

  task automatic test_saturate_and_reset();
    apply_reset();
    for (int i = 0; i < 5; i++) drive(1'b1, 12'hC25);
    drive(1'b1, 12'h042);
    step();
    checks++; if (b_sbe !== 2'd3 || a_sbe !== 16'd5) begin errors++; $display("FAIL saturate got b=%0d a=%0d exp 3/5", b_sbe, a_sbe); end
    checks++; if (a_irq !== 1'b1 || b_mbe !== 2'd1) begin errors++; $display("FAIL pre_reset got irq=%b mbe=%0d exp 1/1", a_irq, b_mbe); end
    drive(1'b1, 12'hC25);
    RST_N = 1'b0;
    step();
    checks++; if ({a_log_valid, a_ovf, a_done, a_irq} !== 4'b0000 || a_sbe !== 16'd0 || a_mbe !== 16'd0) begin errors++; $display("FAIL midstream_reset got %b %0d %0d exp 0000 0 0", {a_log_valid, a_ovf, a_done, a_irq}, a_sbe, a_mbe); end
    RST_N = 1'b1;
    step();
    step();
    checks++; if (a_log_valid !== 1'b0 || a_sbe !== 16'd0) begin errors++; $display("FAIL reset_discard got %b/%0d exp 0/0", a_log_valid, a_sbe); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    RST_N = 1'b0;
    ERROR = 1'b0; SYNDROME = 12'h000; SYNDROMEVALID = 1'b0;
    SCAN_START = 1'b0; CNT_CLR = 1'b0; IRQ_CLR = 1'b0; LOG_READY = 1'b0;
    test_reset();
    test_clean();
    test_sbe();
    test_mbe();
    test_overflow();
    test_full_pop();
    test_scan();
    test_saturate_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
